// File: rtl/gfsk_bitstream_shaper.sv
`default_nettype none
// ============================================================================
// gfsk_bitstream_shaper : byte stream -> NRZ samples -> 7-tap moving-sum code
// Rev 1.0 - initial release
// ============================================================================
module gfsk_bitstream_shaper #(
   parameter int SAMPLES_PER_SYMBOL = 10
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [2:0] io_gfskout,
   output logic       busy,
   output logic       underrun
);
   localparam int CNT_W = $clog2(SAMPLES_PER_SYMBOL);
   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES_PER_SYMBOL - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state;
   logic [7:0]       hold_data;
   logic             hold_last;
   logic             hold_valid;
   logic [7:0]       shifter;
   logic             cur_last;
   logic [2:0]       bit_cnt;
   logic [CNT_W-1:0] sample_cnt;
   logic [6:0]       window;

   logic             cur_bit;
   logic             accept;
   logic             byte_done;
   logic             pull;
   logic [6:0]       window_next;
   logic [2:0]       pop;

   assign in_ready    = !hold_valid;
   assign accept      = in_valid && in_ready;
   assign cur_bit     = (state == SEND) && shifter[0];
   assign byte_done   = (state == SEND) && (bit_cnt == 3'd7) && (sample_cnt == LAST_SAMPLE);
   assign pull        = hold_valid && ((state == IDLE) || byte_done);
   assign window_next = {window[5:0], cur_bit};
   assign busy        = (state != IDLE) || (window != 7'd0);

   always_comb begin
      pop = 3'd0;
      for (int i = 0; i < 7; i++) begin
         pop = pop + {2'b00, window_next[i]};
      end
   end

   // Accept and pull are mutually exclusive: a pull needs hold full, accept needs it empty.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         hold_valid <= 1'b0;
         hold_data  <= 8'd0;
         hold_last  <= 1'b0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold_data  <= in_data;
         hold_last  <= in_last;
      end else if (pull) begin
         hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         shifter    <= 8'd0;
         cur_last   <= 1'b0;
         bit_cnt    <= 3'd0;
         sample_cnt <= '0;
         window     <= 7'd0;
         io_gfskout <= 3'd0;
         underrun   <= 1'b0;
      end else begin
         window     <= window_next;
         io_gfskout <= pop;
         underrun   <= 1'b0;
         case (state)
            IDLE: begin
               if (hold_valid) begin
                  shifter    <= hold_data;
                  cur_last   <= hold_last;
                  bit_cnt    <= 3'd0;
                  sample_cnt <= '0;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (sample_cnt != LAST_SAMPLE) begin
                  sample_cnt <= sample_cnt + 1'b1;
               end else begin
                  sample_cnt <= '0;
                  if (bit_cnt != 3'd7) begin
                     shifter <= {1'b0, shifter[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                  end else if (hold_valid) begin
                     shifter  <= hold_data;
                     cur_last <= hold_last;
                     bit_cnt  <= 3'd0;
                  end else begin
                     underrun <= !cur_last;
                     state    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Leave on the edge that empties the window so busy drops with it.
               if (window[5:0] == 6'd0) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_gfsk_bitstream_shaper.sv
`default_nettype none
// Testbench for gfsk_bitstream_shaper: random and directed packets vs. a sample-stream model.
module tb_gfsk_bitstream_shaper;
   localparam int SPS = 10;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [2:0] io_gfskout;
   logic       busy;
   logic       underrun;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] pkt [16];
   int         pkt_len;
   bit         pkt_last;
   int         busy_cnt;
   int         underrun_cnt;
   int         min_mid;

   gfsk_bitstream_shaper #(.SAMPLES_PER_SYMBOL(SPS)) dut (
      .clock(clock), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .io_gfskout(io_gfskout),
      .busy(busy), .underrun(underrun)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // NRZ sample i of the packet: bytes back to back, LSB first, SPS samples per bit.
   function automatic int samp(int i);
      if (i < 0 || i >= pkt_len * 8 * SPS) return 0;
      return int'(pkt[i / (8 * SPS)][(i / SPS) % 8]);
   endfunction

   task automatic run_packet(input string name, input int max_delay, input bit junk);
      int idx, e_acc, m, len, delay, limit, exp_out, exp_busy, exp_und;
      bit pending, done;
      idx = 0; e_acc = -1; pending = 0; done = 0; delay = 0;
      len = pkt_len * 8 * SPS;
      limit = cyc + len + 400;
      busy_cnt = 0; underrun_cnt = 0; min_mid = 7;
      in_valid = 1'b0;
      while (!done) begin
         @(negedge clock);
         if (pending) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s ready_after_accept cyc=%0d got=%b want=0", name, cyc, in_ready);
            end
            idx++; pending = 0; in_valid = 1'b0;
            delay = (max_delay > 0) ? int'($urandom_range(0, max_delay)) : 0;
         end
         if (busy === 1'b1) busy_cnt++;
         if (underrun === 1'b1) underrun_cnt++;
         if (e_acc >= 0) begin
            m = cyc - (e_acc + 1);
            exp_out = 0;
            for (int i = m - 7; i <= m - 1; i++) exp_out += samp(i);
            exp_busy = ((m >= 0 && m <= len) || exp_out != 0) ? 1 : 0;
            exp_und  = (m == len && !pkt_last) ? 1 : 0;
            if (m >= 8 && m <= len) min_mid = (int'(io_gfskout) < min_mid) ? int'(io_gfskout) : min_mid;
            checks++;
            if (io_gfskout !== 3'(exp_out) || busy !== 1'(exp_busy) || underrun !== 1'(exp_und)) begin
               errors++;
               $display("FAIL %s outputs m=%0d got out=%0d busy=%b und=%b want out=%0d busy=%0d und=%0d",
                        name, m, io_gfskout, busy, underrun, exp_out, exp_busy, exp_und);
            end
            if (m > len + 10) done = 1;
         end else begin
            checks++;
            if (io_gfskout !== 3'd0 || busy !== 1'b0 || underrun !== 1'b0) begin
               errors++;
               $display("FAIL %s idle_before_accept got out=%0d busy=%b und=%b want 0 0 0",
                        name, io_gfskout, busy, underrun);
            end
         end
         if (idx < pkt_len && !done) begin
            if (delay > 0) begin
               delay--;
               in_valid = 1'b0;
            end else if (in_ready === 1'b1) begin
               in_valid = 1'b1;
               in_data  = pkt[idx];
               in_last  = (idx == pkt_len - 1) && pkt_last;
               pending  = 1;
               if (e_acc < 0) e_acc = cyc + 1;
            end else begin
               in_valid = junk;
               in_data  = 8'($urandom);
               in_last  = 1'($urandom);
            end
         end
         if (cyc > limit && !done) begin
            errors++; checks++;
            $display("FAIL %s timeout cyc=%0d got=running want=finished", name, cyc);
            done = 1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (io_gfskout !== 3'd0 || busy !== 1'b0 || underrun !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state got out=%0d busy=%b und=%b rdy=%b want 0 0 0 1",
                  io_gfskout, busy, underrun, in_ready);
      end
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_single_ff();
      pkt[0] = 8'hFF; pkt_len = 1; pkt_last = 1;
      run_packet("single_ff", 0, 0);
      checks++;
      if (underrun_cnt !== 0) begin
         errors++; $display("FAIL single_ff underrun_count got=%0d want=0", underrun_cnt);
      end
   endtask

   task automatic test_zero_byte();
      pkt[0] = 8'h00; pkt_len = 1; pkt_last = 1;
      run_packet("zero_byte", 0, 0);
      checks++;
      if (busy_cnt !== 8 * SPS + 1) begin
         errors++; $display("FAIL zero_byte busy_cycles got=%0d want=%0d", busy_cnt, 8 * SPS + 1);
      end
   endtask

   task automatic test_alternating();
      pkt[0] = 8'h55; pkt_len = 1; pkt_last = 1;
      run_packet("alt_55", 0, 0);
   endtask

   task automatic test_back_to_back();
      pkt[0] = 8'hFF; pkt[1] = 8'hFF; pkt_len = 2; pkt_last = 1;
      run_packet("back_to_back", 0, 1);
      checks++;
      if (min_mid !== 7) begin
         errors++; $display("FAIL back_to_back min_level got=%0d want=7", min_mid);
      end
   endtask

   task automatic test_underrun();
      pkt[0] = 8'hFF; pkt_len = 1; pkt_last = 0;
      run_packet("underrun", 0, 0);
      checks++;
      if (underrun_cnt !== 1) begin
         errors++; $display("FAIL underrun pulse_count got=%0d want=1", underrun_cnt);
      end
   endtask

   task automatic test_eight_bytes();
      for (int i = 0; i < 8; i++) pkt[i] = 8'($urandom);
      pkt_len = 8; pkt_last = 1;
      run_packet("eight_bytes", 20, 1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 10; t++) begin
         pkt_len  = int'($urandom_range(1, 4));
         pkt_last = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < pkt_len; i++) pkt[i] = 8'($urandom);
         run_packet("random", 30, 1'($urandom));
      end
   endtask

   task automatic test_reset_midpacket();
      int n;
      n = 0;
      @(negedge clock);
      in_data = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (20) @(negedge clock);
      checks++;
      if (io_gfskout !== 3'd7) begin
         errors++; $display("FAIL reset_mid pre_level got=%0d want=7", io_gfskout);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (io_gfskout !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1 || underrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid async got out=%0d busy=%b rdy=%b und=%b want 0 0 1 0",
                  io_gfskout, busy, in_ready, underrun);
      end
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      repeat (100) begin
         @(negedge clock);
         if (io_gfskout !== 3'd0 || busy !== 1'b0) n++;
      end
      checks++;
      if (n !== 0) begin
         errors++; $display("FAIL reset_mid residual_cycles got=%0d want=0", n);
      end
   endtask

   initial begin
      test_reset();
      test_single_ff();
      test_zero_byte();
      test_alternating();
      test_back_to_back();
      test_underrun();
      test_eight_bytes();
      test_random();
      test_reset_midpacket();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
